cl_bram_axi_arb: RTL and testbench
==================================

# cl_bram_axi_arb

- Arbitrates two AXI-Lite requesters onto one 64-bit AXI-4 slave port of the CL BRAM controller.
- Requester 0 is the BAR1 register path; requester 1 is the second management/DMA agent.
- Carries one single-beat transaction at a time and does 32-to-64-bit lane steering.
- Holds off all grants while the BRAM controller reports reset-busy.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: downstream response watchdog limit. Used only when the watchdog is compiled in.
- `AWID_BASE`, default 4'h0: AXI ID issued is `AWID_BASE + requester index`, on both AW and AR.

Ports:
- `clk_main_a0` in 1: the only clock.
- `rst_main` in 1: reset, synchronous and active-high.
- `req_awvalid`/`req_awready` in/out [1:0]; `req_awaddr` in [1:0][31:0].
- `req_wvalid`/`req_wready` in/out [1:0]; `req_wdata` in [1:0][31:0]; `req_wstrb` in [1:0][3:0].
- `req_bvalid` out [1:0]; `req_bresp` out [1:0][1:0]; `req_bready` in [1:0].
- `req_arvalid`/`req_arready` in/out [1:0]; `req_araddr` in [1:0][31:0].
- `req_rvalid` out [1:0]; `req_rdata` out [1:0][31:0]; `req_rresp` out [1:0][1:0]; `req_rready` in [1:0].
- `rsta_busy`, `rstb_busy` in 1: BRAM controller reset-busy flags. Grants are allowed only when both are low.
- AXI-4 master, write side:
  - `s_axi_aw{id[3:0],addr[31:0],len[7:0],size[2:0],burst[1:0],valid}` out; `s_axi_awready` in.
  - `s_axi_w{data[63:0],strb[7:0],last,valid}` out; `s_axi_wready` in.
  - `s_axi_b{id,resp,valid}` in; `s_axi_bready` out.
- AXI-4 master, read side:
  - `s_axi_ar{id,addr,len,size,burst,valid}` out; `s_axi_arready` in.
  - `s_axi_r{id,data[63:0],resp,last,valid}` in; `s_axi_rready` out.
- `err_timeout` out 1: sticky watchdog flag. Tied to 0 when the watchdog is compiled out.

## Operation
- Slots: 0 = req0 write, 1 = req0 read, 2 = req1 write, 3 = req1 read.
  - A write slot is pending when `awvalid & wvalid`.
  - A read slot is pending when `arvalid`.
- Round-robin: a 2-bit pointer `rr_ptr` holds the last granted slot.
  - The search starts at `rr_ptr+1` and wraps from 3 to 0.
  - Reset value of `rr_ptr` is 3, so slot 0 has first priority.
- State machine:
  - IDLE: a grant is made only when a slot is pending and both busy flags are low.
    - Write grant: captures addr/data/strb and pulses that requester's `awready` and `wready` for 1 cycle. Next state WADDR.
    - Read grant: captures addr and pulses `arready`. Next state RADDR.
  - WADDR: `s_axi_awvalid` and `s_axi_wvalid` are asserted together. Each drops independently when accepted. When both are done, go to WRESP.
  - WRESP: `s_axi_bready`=1. On `bvalid`, capture `bresp` and go to BRESP.
  - BRESP: `req_bvalid[g]`=1 until `req_bready[g]`, then go to IDLE.
  - RADDR: `s_axi_arvalid`=1. On `arready`, go to RDATA.
  - RDATA: `s_axi_rready`=1. On `rvalid`, capture data and resp and go to RRESP.
  - RRESP: `req_rvalid[g]`=1 until `req_rready[g]`, then go to IDLE.
- Fixed AXI-4 fields:
  - `len`=0 (single beat), `size`=3'b010, `burst`=2'b01, `wlast`=1.
- Lane steering uses `addr[2]`:
  - 0: data and strobe go on the low lane (`wstrb={4'h0,strb}`); read data is `rdata[31:0]`.
  - 1: data and strobe go on the high lane (`wstrb={strb,4'h0}`); read data is `rdata[63:32]`.
  - `addr[2]` is latched at grant for use on the read return.
- `bid`, `rid` and `rlast` are ignored.
- Non-granted requesters see all of their ready/valid outputs at 0.

## Timing
- Reset values: all outputs are 0, state is IDLE, `rr_ptr`=3, `err_timeout`=0.
- Reset asserted mid-transaction returns the block to IDLE the next cycle. The in-flight transaction is abandoned; the BRAM controller is reset on the same `rst_main`.
- Minimum latencies, with a zero-wait slave:
  - Request to `req_bvalid`: 3 cycles. Grant at cycle 0, AW/W at 1, B at 2, `req_bvalid` at 3.
  - Request to `req_rvalid`: same 3-cycle count.
- Back-to-back: after a response handshake, the next grant is made no earlier than the following cycle (1 IDLE cycle).
- Simultaneous requests from all 4 slots are granted in ptr order and never starve.
- A busy flag rising while the block is not in IDLE does not abort the transaction. It only blocks the next grant.
- Requester-side valid signals are registered, not combinational from slave inputs.

## Configuration
- `CL_BRAM_ARB_TIMEOUT_EN` defined:
  - A counter runs in WADDR, WRESP, RADDR and RDATA.
  - When it reaches `TIMEOUT_CYCLES`, the block completes to the requester with resp 2'b10 (SLVERR), read data 0, and sets `err_timeout`.
  - A drain flag then holds `bready`/`rready` high until the late response arrives and is discarded. No grant is made while drain is set.
- Not defined: there is no counter and the block waits indefinitely; `err_timeout` is tied to 0.

## Structure
- Package `cl_bram_arb_pkg` holds:
  - the state enum;
  - slot encoding constants;
  - AXI constants: `AXI_SIZE_4B`, `AXI_BURST_INCR`, `AXI_RESP_SLVERR`.
- Sub-module `cl_rr_arb4`: combinational 4-slot round-robin picker. Inputs are the pending slots and `rr_ptr`; outputs are a grant valid flag and the granted index.

## Test plan
- Reset: all outputs are 0. req0 write to 0x10 with data 0xA5A5A5A5 and strb 0xF → `wstrb`=0x0F, `wdata[31:0]`=0xA5A5A5A5, `awid`=0, bresp OKAY returned.
- Read 0x14 after the slave returns rdata 0x11112222_33334444 → `req_rdata`=0x11112222 (high lane).
- All 4 slots pending continuously → grant order is 0,1,2,3,0; no slot waits more than 3 grants.
- `rsta_busy`=1 with req1 read pending → no `arvalid` until `rsta_busy` drops, then grant in the next cycle.
- With the macro and `TIMEOUT_CYCLES`=16: slave never asserts `bvalid` → `req_bresp`=2'b10 after 16 cycles and `err_timeout`=1. A later `bvalid` is dropped, then the next request is served normally.
- `rst_main` pulsed during WRESP → IDLE and all outputs 0 on the next cycle, `rr_ptr`=3.

Source files
------------

// File: rtl/cl_bram_arb_pkg.sv
// Shared types and constants for the CL BRAM AXI arbiter.
package cl_bram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WADDR, ST_WRESP, ST_BRESP, ST_RADDR, ST_RDATA, ST_RRESP
  } arb_state_e;

  // slot index = {requester, is_read}
  localparam logic [1:0] SLOT_R0_WR = 2'd0;
  localparam logic [1:0] SLOT_R0_RD = 2'd1;
  localparam logic [1:0] SLOT_R1_WR = 2'd2;
  localparam logic [1:0] SLOT_R1_RD = 2'd3;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/cl_rr_arb4.sv
// Combinational 4-slot round-robin picker; search starts one past rr_ptr.
module cl_rr_arb4 (
  input  logic [3:0] pend,
  input  logic [1:0] rr_ptr,
  output logic       gnt_vld,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;

  // Walk from farthest to nearest so the nearest pending slot wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    cand    = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = rr_ptr + 2'(i);
      if (pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/cl_bram_axi_arb.sv
// Two AXI-Lite requesters onto one 64-bit AXI-4 BRAM port, one beat in flight.
// Optional response watchdog: define CL_BRAM_ARB_TIMEOUT_EN.
module cl_bram_axi_arb
  import cl_bram_arb_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [3:0] AWID_BASE      = 4'h0
) (
  input  logic              clk_main_a0,
  input  logic              rst_main,
  input  logic [1:0]        req_awvalid,
  output logic [1:0]        req_awready,
  input  logic [1:0][31:0]  req_awaddr,
  input  logic [1:0]        req_wvalid,
  output logic [1:0]        req_wready,
  input  logic [1:0][31:0]  req_wdata,
  input  logic [1:0][3:0]   req_wstrb,
  output logic [1:0]        req_bvalid,
  output logic [1:0][1:0]   req_bresp,
  input  logic [1:0]        req_bready,
  input  logic [1:0]        req_arvalid,
  output logic [1:0]        req_arready,
  input  logic [1:0][31:0]  req_araddr,
  output logic [1:0]        req_rvalid,
  output logic [1:0][31:0]  req_rdata,
  output logic [1:0][1:0]   req_rresp,
  input  logic [1:0]        req_rready,
  input  logic              rsta_busy,
  input  logic              rstb_busy,
  output logic [3:0]        s_axi_awid,
  output logic [31:0]       s_axi_awaddr,
  output logic [7:0]        s_axi_awlen,
  output logic [2:0]        s_axi_awsize,
  output logic [1:0]        s_axi_awburst,
  output logic              s_axi_awvalid,
  input  logic              s_axi_awready,
  output logic [63:0]       s_axi_wdata,
  output logic [7:0]        s_axi_wstrb,
  output logic              s_axi_wlast,
  output logic              s_axi_wvalid,
  input  logic              s_axi_wready,
  input  logic [3:0]        s_axi_bid,
  input  logic [1:0]        s_axi_bresp,
  input  logic              s_axi_bvalid,
  output logic              s_axi_bready,
  output logic [3:0]        s_axi_arid,
  output logic [31:0]       s_axi_araddr,
  output logic [7:0]        s_axi_arlen,
  output logic [2:0]        s_axi_arsize,
  output logic [1:0]        s_axi_arburst,
  output logic              s_axi_arvalid,
  input  logic              s_axi_arready,
  input  logic [3:0]        s_axi_rid,
  input  logic [63:0]       s_axi_rdata,
  input  logic [1:0]        s_axi_rresp,
  input  logic              s_axi_rlast,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready,
  output logic              err_timeout
);

  arb_state_e  state, state_nxt;
  logic [1:0]  rr_ptr, arb_idx, resp_q;
  logic [3:0]  pend;
  logic        arb_vld, can_gnt, gnt_rd, gnt_r;
  logic        gnt_q, hi_q, aw_pend, w_pend, ar_pend;
  logic        aw_done, w_done, tmo_fire, drain, drain_rd;
  logic [31:0] addr_q, rdata_q, gnt_addr;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  always_comb begin
    pend             = '0;
    pend[SLOT_R0_WR] = req_awvalid[0] & req_wvalid[0];
    pend[SLOT_R0_RD] = req_arvalid[0];
    pend[SLOT_R1_WR] = req_awvalid[1] & req_wvalid[1];
    pend[SLOT_R1_RD] = req_arvalid[1];
  end

  cl_rr_arb4 u_arb (.pend(pend), .rr_ptr(rr_ptr), .gnt_vld(arb_vld), .gnt_idx(arb_idx));

  assign can_gnt  = (state == ST_IDLE) & arb_vld & ~rsta_busy & ~rstb_busy & ~drain & ~rst_main;
  assign gnt_rd   = arb_idx[0];
  assign gnt_r    = arb_idx[1];
  assign gnt_addr = gnt_rd ? req_araddr[gnt_r] : req_awaddr[gnt_r];
  assign aw_done  = ~aw_pend | s_axi_awready;
  assign w_done   = ~w_pend | s_axi_wready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (can_gnt) state_nxt = gnt_rd ? ST_RADDR : ST_WADDR;
      ST_WADDR: if (aw_done & w_done) state_nxt = ST_WRESP;
                else if (tmo_fire)    state_nxt = ST_BRESP;
      ST_WRESP: if (s_axi_bvalid | tmo_fire) state_nxt = ST_BRESP;
      ST_BRESP: if (req_bready[gnt_q]) state_nxt = ST_IDLE;
      ST_RADDR: if (s_axi_arready)  state_nxt = ST_RDATA;
                else if (tmo_fire)  state_nxt = ST_RRESP;
      ST_RDATA: if (s_axi_rvalid | tmo_fire) state_nxt = ST_RRESP;
      ST_RRESP: if (req_rready[gnt_q]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state   <= ST_IDLE;
      rr_ptr  <= 2'd3;
      gnt_q   <= 1'b0;
      hi_q    <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (aw_pend & s_axi_awready) aw_pend <= 1'b0;
      if (w_pend & s_axi_wready)   w_pend  <= 1'b0;
      if (ar_pend & s_axi_arready) ar_pend <= 1'b0;
      if (can_gnt) begin
        rr_ptr  <= arb_idx;
        gnt_q   <= gnt_r;
        addr_q  <= gnt_addr;
        hi_q    <= gnt_addr[2];
        aw_pend <= ~gnt_rd;
        w_pend  <= ~gnt_rd;
        ar_pend <= gnt_rd;
        wdata_q <= gnt_addr[2] ? {req_wdata[gnt_r], 32'h0} : {32'h0, req_wdata[gnt_r]};
        wstrb_q <= gnt_addr[2] ? {req_wstrb[gnt_r], 4'h0} : {4'h0, req_wstrb[gnt_r]};
      end
      if (tmo_fire) begin
        resp_q  <= AXI_RESP_SLVERR;
        rdata_q <= '0;
      end else if (state == ST_WRESP && s_axi_bvalid) begin
        resp_q  <= s_axi_bresp;
      end else if (state == ST_RDATA && s_axi_rvalid) begin
        resp_q  <= s_axi_rresp;
        rdata_q <= hi_q ? s_axi_rdata[63:32] : s_axi_rdata[31:0];
      end
    end
  end

  // Fixed fields are zeroed while their channel is idle so reset shows all-zero.
  assign s_axi_awvalid = aw_pend;
  assign s_axi_awid    = aw_pend ? AWID_BASE + 4'(gnt_q) : 4'h0;
  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = 8'h0;
  assign s_axi_awsize  = aw_pend ? AXI_SIZE_4B : 3'b0;
  assign s_axi_awburst = aw_pend ? AXI_BURST_INCR : 2'b0;
  assign s_axi_wvalid  = w_pend;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wstrb   = wstrb_q;
  assign s_axi_wlast   = w_pend;
  assign s_axi_arvalid = ar_pend;
  assign s_axi_arid    = ar_pend ? AWID_BASE + 4'(gnt_q) : 4'h0;
  assign s_axi_araddr  = addr_q;
  assign s_axi_arlen   = 8'h0;
  assign s_axi_arsize  = ar_pend ? AXI_SIZE_4B : 3'b0;
  assign s_axi_arburst = ar_pend ? AXI_BURST_INCR : 2'b0;
  assign s_axi_bready  = (state == ST_WRESP) | (drain & ~drain_rd);
  assign s_axi_rready  = (state == ST_RDATA) | (drain & drain_rd);

  for (genvar g = 0; g < 2; g++) begin : g_req
    assign req_awready[g] = can_gnt & ~gnt_rd & (gnt_r == 1'(g));
    assign req_wready[g]  = can_gnt & ~gnt_rd & (gnt_r == 1'(g));
    assign req_arready[g] = can_gnt &  gnt_rd & (gnt_r == 1'(g));
    assign req_bvalid[g]  = (state == ST_BRESP) & (gnt_q == 1'(g));
    assign req_bresp[g]   = req_bvalid[g] ? resp_q : 2'b0;
    assign req_rvalid[g]  = (state == ST_RRESP) & (gnt_q == 1'(g));
    assign req_rresp[g]   = req_rvalid[g] ? resp_q : 2'b0;
    assign req_rdata[g]   = req_rvalid[g] ? rdata_q : 32'h0;
  end

  logic unused_axi;
  assign unused_axi = ^{s_axi_bid, s_axi_rid, s_axi_rlast};

`ifdef CL_BRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 2;
  logic [CW-1:0] tmo_cnt;
  logic          in_wait, at_lim, err_q;

  assign in_wait = state inside {ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA};
  assign at_lim  = tmo_cnt >= CW'(TIMEOUT_CYCLES - 1);
  // Fire only when the stage is not completing this very cycle.
  assign tmo_fire = at_lim & (((state == ST_WADDR) & ~(aw_done & w_done)) |
                              ((state == ST_WRESP) & ~s_axi_bvalid) |
                              ((state == ST_RADDR) & ~s_axi_arready) |
                              ((state == ST_RDATA) & ~s_axi_rvalid));

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      tmo_cnt  <= '0;
      drain    <= 1'b0;
      drain_rd <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tmo_cnt <= in_wait ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire) begin
        drain    <= 1'b1;
        drain_rd <= (state == ST_RADDR) | (state == ST_RDATA);
        err_q    <= 1'b1;
      end else if (drain & (drain_rd ? s_axi_rvalid : s_axi_bvalid)) begin
        drain    <= 1'b0;
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_fire    = 1'b0;
  assign drain       = 1'b0;
  assign drain_rd    = 1'b0;
  assign err_timeout = 1'b0;

  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_cl_bram_axi_arb.sv
// Directed bench for cl_bram_axi_arb with a zero-wait BRAM slave model.
module tb_cl_bram_axi_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rsta_busy, rstb_busy, no_b;
  logic [1:0]       req_awvalid, req_awready, req_wvalid, req_wready, req_bvalid, req_bready;
  logic [1:0]       req_arvalid, req_arready, req_rvalid, req_rready;
  logic [1:0][31:0] req_awaddr, req_wdata, req_araddr, req_rdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0][1:0]  req_bresp, req_rresp;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, err_timeout;
  logic [63:0] s_axi_wdata, s_axi_rdata;

  int n_vec = 0;
  int n_err = 0;

  cl_bram_axi_arb #(.TIMEOUT_CYCLES(16), .AWID_BASE(4'h0)) dut (
    .clk_main_a0(clk), .rst_main(rst),
    .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_bvalid(req_bvalid), .req_bresp(req_bresp), .req_bready(req_bready),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rready(req_rready),
    .rsta_busy(rsta_busy), .rstb_busy(rstb_busy),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .err_timeout(err_timeout)
  );

  // Zero-wait slave: always ready, B/R one cycle after the address handshake.
  logic [63:0] mem [0:31];
  logic        b_owed;
  logic [3:0]  cap_awid, cap_arid;
  logic [31:0] cap_awaddr, cap_araddr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  logic [13:0] cap_fixed;

  assign s_axi_awready = 1'b1;
  assign s_axi_wready  = 1'b1;
  assign s_axi_arready = 1'b1;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_bid     = 4'h0;
  assign s_axi_rid     = 4'h0;
  assign s_axi_rlast   = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      b_owed       <= 1'b0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
      if (s_axi_awvalid && s_axi_wvalid) begin
        cap_awid   <= s_axi_awid;
        cap_awaddr <= s_axi_awaddr;
        cap_wdata  <= s_axi_wdata;
        cap_wstrb  <= s_axi_wstrb;
        cap_fixed  <= {s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_wlast};
        for (int i = 0; i < 8; i++)
          if (s_axi_wstrb[i]) mem[s_axi_awaddr[7:3]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
      if ((s_axi_awvalid || b_owed) && !no_b) begin
        s_axi_bvalid <= 1'b1;
        b_owed       <= 1'b0;
      end else if (s_axi_awvalid) begin
        b_owed <= 1'b1;
      end
      if (s_axi_arvalid) begin
        cap_arid     <= s_axi_arid;
        cap_araddr   <= s_axi_araddr;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= mem[s_axi_araddr[7:3]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_axi_vld"}, {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready,
                            s_axi_rready, s_axi_wlast}, 64'h0);
    chk({tag, "_axi_addr"}, {s_axi_awaddr, s_axi_araddr}, 64'h0);
    chk({tag, "_axi_wdata"}, s_axi_wdata, 64'h0);
    chk({tag, "_axi_fields"}, {s_axi_awid, s_axi_arid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                               s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_wstrb}, 64'h0);
    chk({tag, "_req_hs"}, {req_awready, req_wready, req_arready, req_bvalid, req_rvalid,
                           req_bresp, req_rresp}, 64'h0);
    chk({tag, "_req_rdata"}, req_rdata, 64'h0);
    chk({tag, "_err"}, err_timeout, 64'h0);
  endtask

  // One single-beat transaction; lat counts cycles from grant to response valid.
  task automatic txn(input logic rd, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [1:0] resp, output logic [31:0] rdat,
                     output int lat);
    int n;
    logic vld;
    resp = 2'bxx; rdat = 'x; lat = 0;
    @(posedge clk); #1;
    if (rd) begin
      req_arvalid[r] = 1'b1; req_araddr[r] = a;
    end else begin
      req_awvalid[r] = 1'b1; req_wvalid[r] = 1'b1;
      req_awaddr[r] = a; req_wdata[r] = d; req_wstrb[r] = s;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(rd ? req_arready[r] : (req_awready[r] & req_wready[r])) && n < 200);
    if (n >= 200) chk("grant_wait", 0, 1);
    @(posedge clk); #1;
    req_arvalid[r] = 1'b0; req_awvalid[r] = 1'b0; req_wvalid[r] = 1'b0;
    do begin
      @(negedge clk); lat++;
      vld = rd ? req_rvalid[r] : req_bvalid[r];
    end while (!vld && lat < 200);
    if (!vld) chk("resp_wait", 0, 1);
    resp = rd ? req_rresp[r] : req_bresp[r];
    rdat = req_rdata[r];
    chk("other_req_idle", {req_bvalid[!r], req_rvalid[!r]}, 0);
    @(posedge clk);
  endtask

  typedef struct packed {
    logic        rd;
    logic        r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  exp_strb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t v [12];
  int   rr_exp [5];
  int   order [$];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdat, lane;
    int          lat, n;
    logic        flag;

    v[0]  = '{1'b0, 1'b0, 32'h10, 32'hA5A5A5A5, 4'hF, 8'h0F, 32'h0};
    v[1]  = '{1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 8'hF0, 32'h0};
    v[2]  = '{1'b0, 1'b0, 32'h08, 32'h12345678, 4'h3, 8'h03, 32'h0};
    v[3]  = '{1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'h8, 8'h80, 32'h0};
    v[4]  = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 8'h0, 32'hA5A5A5A5};
    v[5]  = '{1'b1, 1'b1, 32'h14, 32'h0, 4'h0, 8'h0, 32'hDEADBEEF};
    v[6]  = '{1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 8'h0, 32'h00005678};
    v[7]  = '{1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 8'h0, 32'hCA000000};
    v[8]  = '{1'b0, 1'b0, 32'h10, 32'h33334444, 4'hF, 8'h0F, 32'h0};
    v[9]  = '{1'b0, 1'b1, 32'h14, 32'h11112222, 4'hF, 8'hF0, 32'h0};
    v[10] = '{1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 8'h0, 32'h11112222};
    v[11] = '{1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 8'h0, 32'h33334444};
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; rsta_busy = 1'b0; rstb_busy = 1'b0; no_b = 1'b0;
    req_awvalid = '0; req_wvalid = '0; req_arvalid = '0;
    req_awaddr = '0; req_wdata = '0; req_wstrb = '0; req_araddr = '0;
    req_bready = 2'b11; req_rready = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("rst");

    for (int i = 0; i < 12; i++) begin
      txn(v[i].rd, v[i].r, v[i].addr, v[i].data, v[i].strb, resp, rdat, lat);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_resp", i), resp, 2'b00);
      if (v[i].rd) begin
        chk($sformatf("v%0d_arid", i), cap_arid, 4'(v[i].r));
        chk($sformatf("v%0d_araddr", i), cap_araddr, v[i].addr);
        chk($sformatf("v%0d_rdata", i), rdat, v[i].exp_rdata);
      end else begin
        lane = v[i].addr[2] ? cap_wdata[63:32] : cap_wdata[31:0];
        chk($sformatf("v%0d_awid", i), cap_awid, 4'(v[i].r));
        chk($sformatf("v%0d_awaddr", i), cap_awaddr, v[i].addr);
        chk($sformatf("v%0d_wstrb", i), cap_wstrb, v[i].exp_strb);
        chk($sformatf("v%0d_wlane", i), lane, v[i].data);
        chk($sformatf("v%0d_fixed", i), cap_fixed, {8'h0, 3'b010, 2'b01, 1'b1});
      end
    end

    // Busy flag holds off a pending read; grant follows once it drops.
    @(posedge clk); #1;
    rsta_busy = 1'b1; req_arvalid[1] = 1'b1; req_araddr[1] = 32'h14;
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      flag |= req_arready[1] | s_axi_arvalid;
    end
    chk("busy_hold", flag, 0);
    @(posedge clk); #1 rsta_busy = 1'b0;
    @(negedge clk);
    flag = req_arready[1];
    if (!flag) begin
      @(negedge clk);
      flag = req_arready[1];
    end
    chk("busy_release_gnt", flag, 1);
    @(posedge clk); #1 req_arvalid[1] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_rvalid[1] && n < 50);
    chk("busy_rdata", req_rdata[1], 32'h11112222);
    @(posedge clk);

    // Reset pulsed while waiting for B.
    @(posedge clk); #1;
    no_b = 1'b1;
    req_awvalid[0] = 1'b1; req_wvalid[0] = 1'b1; req_awaddr[0] = 32'h18;
    req_wdata[0] = 32'h0BADF00D; req_wstrb[0] = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_awready[0] && n < 50);
    @(posedge clk); #1 req_awvalid[0] = 1'b0; req_wvalid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bready && n < 50);
    chk("wresp_reached", s_axi_bready, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; no_b = 1'b0;
    @(negedge clk);
    chk_zero("midrst");

    // All four slots pending; pointer restarted at 3 so slot 0 leads.
    @(posedge clk); #1;
    req_awaddr = {32'h48, 32'h40}; req_araddr = {32'h48, 32'h40};
    req_wdata = {32'h2222, 32'h1111}; req_wstrb = {4'hF, 4'hF};
    req_awvalid = 2'b11; req_wvalid = 2'b11; req_arvalid = 2'b11;
    n = 0;
    while (order.size() < 5 && n < 300) begin
      @(negedge clk); n++;
      if (req_awready[0]) order.push_back(0);
      if (req_arready[0]) order.push_back(1);
      if (req_awready[1]) order.push_back(2);
      if (req_arready[1]) order.push_back(3);
    end
    @(posedge clk); #1;
    req_awvalid = '0; req_wvalid = '0; req_arvalid = '0;
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : 99, rr_exp[i]);
    repeat (10) @(posedge clk);

`ifdef CL_BRAM_ARB_TIMEOUT_EN
    no_b = 1'b1;
    txn(1'b0, 1'b0, 32'h20, 32'h5555AAAA, 4'hF, resp, rdat, lat);
    chk("tmo_resp", resp, 2'b10);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_lat_window", (lat >= 16 && lat <= 18), 1);
    @(posedge clk); #1 no_b = 1'b0;
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      flag |= req_bvalid[0] | req_bvalid[1];
    end
    chk("tmo_late_b_dropped", flag, 0);
    chk("tmo_drained", s_axi_bvalid, 0);
    txn(1'b0, 1'b1, 32'h24, 32'h77778888, 4'hF, resp, rdat, lat);
    chk("post_tmo_resp", resp, 2'b00);
    chk("post_tmo_lat", lat, 3);
    chk("post_tmo_err_sticky", err_timeout, 1);
`else
    chk("err_tied_low", err_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
